// File: rtl/vision_pkg.sv
// Shared command, lane and controller-state encodings for the vision command path.
package vision_pkg;

    typedef enum logic [1:0] {
        CMD_NONE  = 2'd0,
        CMD_LEFT  = 2'd1,
        CMD_RIGHT = 2'd2,
        CMD_JUMP  = 2'd3
    } cmd_t;

    localparam logic [1:0] LANE_LEFT    = 2'd0;
    localparam logic [1:0] LANE_MID     = 2'd1;
    localparam logic [1:0] LANE_RIGHT   = 2'd2;
    localparam logic [1:0] LANE_INVALID = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } ctrl_state_t;

endpackage

// File: rtl/vision_frame_filter.sv
// Per-frame debounce of the vision results: stable target lane, jump arming and
// player-lost detection, all advanced once per rising edge of data_valid_in.
module vision_frame_filter
    import vision_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned JUMP_FRAMES   = 2,
    parameter int unsigned LOST_FRAMES   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_valid_in,
    input  logic [1:0] lane_in,
    input  logic       jump_in,
    input  logic [8:0] quadrants_in,
    output logic       frame_tick,
    output logic [1:0] target_lane,
    output logic       jump_arm_pulse,
    output logic       player_lost
);

    localparam logic [3:0] STABLE_MAX = 4'(STABLE_FRAMES);
    localparam logic [3:0] JUMP_MAX   = 4'(JUMP_FRAMES);
    localparam logic [3:0] LOST_MAX   = 4'(LOST_FRAMES);

    logic       dv_q;
    logic [3:0] stable_cnt_q, stable_cnt_d;
    logic [3:0] jump_cnt_q, jump_cnt_d;
    logic [3:0] lost_cnt_q, lost_cnt_d;
    logic [1:0] cand_lane_q, cand_lane_d;
    logic [1:0] target_lane_q, target_lane_d;
    logic       player_lost_q, player_lost_d;
    logic       det;

    always_comb begin
        stable_cnt_d   = stable_cnt_q;
        jump_cnt_d     = jump_cnt_q;
        lost_cnt_d     = lost_cnt_q;
        cand_lane_d    = cand_lane_q;
        target_lane_d  = target_lane_q;
        player_lost_d  = player_lost_q;
        jump_arm_pulse = 1'b0;

        frame_tick = data_valid_in & ~dv_q;
        det        = (quadrants_in != 9'd0) && (lane_in != LANE_INVALID);

        if (frame_tick) begin
            if (det) begin
                lost_cnt_d    = 4'd0;
                player_lost_d = 1'b0;
                if (lane_in == cand_lane_q) begin
                    stable_cnt_d = (stable_cnt_q >= STABLE_MAX) ? STABLE_MAX : stable_cnt_q + 4'd1;
                end else begin
                    cand_lane_d  = lane_in;
                    stable_cnt_d = 4'd1;
                end
                // The candidate is lane_in on either branch, so promote it directly.
                if (stable_cnt_d == STABLE_MAX) target_lane_d = lane_in;
                if (jump_in) begin
                    jump_cnt_d = (jump_cnt_q >= JUMP_MAX) ? JUMP_MAX : jump_cnt_q + 4'd1;
                end else begin
                    jump_cnt_d = 4'd0;
                end
                jump_arm_pulse = (jump_cnt_d == JUMP_MAX) && (jump_cnt_q != JUMP_MAX);
            end else begin
                stable_cnt_d = 4'd0;
                jump_cnt_d   = 4'd0;
                lost_cnt_d   = (lost_cnt_q >= LOST_MAX) ? LOST_MAX : lost_cnt_q + 4'd1;
                if ({1'b0, lost_cnt_q} + 5'd1 >= {1'b0, LOST_MAX}) player_lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dv_q          <= 1'b0;
            stable_cnt_q  <= 4'd0;
            jump_cnt_q    <= 4'd0;
            lost_cnt_q    <= 4'd0;
            cand_lane_q   <= LANE_MID;
            target_lane_q <= LANE_MID;
            player_lost_q <= 1'b0;
        end else begin
            dv_q          <= data_valid_in;
            stable_cnt_q  <= stable_cnt_d;
            jump_cnt_q    <= jump_cnt_d;
            lost_cnt_q    <= lost_cnt_d;
            cand_lane_q   <= cand_lane_d;
            target_lane_q <= target_lane_d;
            player_lost_q <= player_lost_d;
        end
    end

    assign target_lane = target_lane_q;
    assign player_lost = player_lost_q;

endmodule

// File: rtl/vision_cmd_ctrl.sv
// Turns filtered vision results into rate-limited LEFT/RIGHT/JUMP commands over a
// valid/ready handshake, tracking the committed player lane.
module vision_cmd_ctrl
    import vision_pkg::*;
#(
    parameter int unsigned STABLE_FRAMES   = 3,
    parameter int unsigned JUMP_FRAMES     = 2,
    parameter int unsigned LOST_FRAMES     = 15,
    parameter int unsigned COOLDOWN_FRAMES = 20,
    parameter int unsigned GAP_CYCLES      = 4
) (
    input  logic       pixel_clock_in,
    input  logic       rst_in,
    input  logic       enable_in,
    input  logic [1:0] lane_in,
    input  logic       jump_in,
    input  logic [8:0] quadrants_in,
    input  logic       data_valid_in,
    input  logic       cmd_ready_in,
    output logic       cmd_valid,
    output logic [1:0] cmd_code,
    output logic [1:0] cur_lane,
    output logic       player_lost
);

    localparam logic [7:0] COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES);
    localparam logic [3:0] GAP_LOAD      = 4'(GAP_CYCLES);

    logic        frame_tick;
    logic [1:0]  target_lane;
    logic        jump_arm_pulse;

    ctrl_state_t state_q, state_d;
    logic        cmd_valid_q, cmd_valid_d;
    cmd_t        cmd_code_q, cmd_code_d;
    logic [1:0]  cur_lane_q, cur_lane_d;
    logic [3:0]  gap_cnt_q, gap_cnt_d;
    logic [7:0]  cooldown_q, cooldown_d;
    logic        jump_pending_q, jump_pending_d;
    cmd_t        next_cmd;

    vision_frame_filter #(
        .STABLE_FRAMES (STABLE_FRAMES),
        .JUMP_FRAMES   (JUMP_FRAMES),
        .LOST_FRAMES   (LOST_FRAMES)
    ) u_filter (
        .clk            (pixel_clock_in),
        .rst            (rst_in),
        .data_valid_in  (data_valid_in),
        .lane_in        (lane_in),
        .jump_in        (jump_in),
        .quadrants_in   (quadrants_in),
        .frame_tick     (frame_tick),
        .target_lane    (target_lane),
        .jump_arm_pulse (jump_arm_pulse),
        .player_lost    (player_lost)
    );

    always_comb begin
        state_d        = state_q;
        cmd_valid_d    = cmd_valid_q;
        cmd_code_d     = cmd_code_q;
        cur_lane_d     = cur_lane_q;
        gap_cnt_d      = gap_cnt_q;
        cooldown_d     = cooldown_q;
        jump_pending_d = jump_pending_q;
        next_cmd       = CMD_NONE;

        if (frame_tick && cooldown_q != 8'd0) cooldown_d = cooldown_q - 8'd1;
        if (jump_arm_pulse && cooldown_q == 8'd0) jump_pending_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (enable_in && !player_lost) begin
                    if (jump_pending_q)                next_cmd = CMD_JUMP;
                    else if (target_lane < cur_lane_q) next_cmd = CMD_LEFT;
                    else if (target_lane > cur_lane_q) next_cmd = CMD_RIGHT;
                end
                if (next_cmd != CMD_NONE) begin
                    cmd_valid_d = 1'b1;
                    cmd_code_d  = next_cmd;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Offer stays up regardless of enable_in until the consumer takes it.
                if (cmd_valid_q && cmd_ready_in) begin
                    case (cmd_code_q)
                        CMD_LEFT:  if (cur_lane_q != LANE_LEFT)  cur_lane_d = cur_lane_q - 2'd1;
                        CMD_RIGHT: if (cur_lane_q != LANE_RIGHT) cur_lane_d = cur_lane_q + 2'd1;
                        CMD_JUMP: begin
                            jump_pending_d = 1'b0;
                            cooldown_d     = COOLDOWN_LOAD;
                        end
                        default: ;
                    endcase
                    cmd_valid_d = 1'b0;
                    cmd_code_d  = CMD_NONE;
                    gap_cnt_d   = GAP_LOAD;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_cnt_q == 4'd0) state_d = S_IDLE;
                else                   gap_cnt_d = gap_cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge pixel_clock_in) begin
        if (rst_in) begin
            state_q        <= S_IDLE;
            cmd_valid_q    <= 1'b0;
            cmd_code_q     <= CMD_NONE;
            cur_lane_q     <= LANE_MID;
            gap_cnt_q      <= 4'd0;
            cooldown_q     <= 8'd0;
            jump_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_code_q     <= cmd_code_d;
            cur_lane_q     <= cur_lane_d;
            gap_cnt_q      <= gap_cnt_d;
            cooldown_q     <= cooldown_d;
            jump_pending_q <= jump_pending_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign cur_lane  = cur_lane_q;

endmodule

// File: tb/tb_vision_cmd_ctrl.sv
// Scenario bench for vision_cmd_ctrl with a frame-history reference model and
// a per-cycle handshake monitor.
module tb_vision_cmd_ctrl;

    localparam int SF = 3;
    localparam int JF = 2;
    localparam int LF = 15;
    localparam int CF = 20;
    localparam int GC = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       dv = 1'b0;
    logic       jump = 1'b0;
    logic       ready = 1'b0;
    logic [1:0] lane = 2'd1;
    logic [8:0] quads = 9'd0;
    logic       cmd_valid;
    logic [1:0] cmd_code;
    logic [1:0] cur_lane;
    logic       player_lost;

    int passed = 0;
    int total  = 0;
    bit rnd_mode = 0;

    always #5 clk = ~clk;

    vision_cmd_ctrl #(
        .STABLE_FRAMES   (SF),
        .JUMP_FRAMES     (JF),
        .LOST_FRAMES     (LF),
        .COOLDOWN_FRAMES (CF),
        .GAP_CYCLES      (GC)
    ) dut (
        .pixel_clock_in (clk),
        .rst_in         (rst),
        .enable_in      (en),
        .lane_in        (lane),
        .jump_in        (jump),
        .quadrants_in   (quads),
        .data_valid_in  (dv),
        .cmd_ready_in   (ready),
        .cmd_valid      (cmd_valid),
        .cmd_code       (cmd_code),
        .cur_lane       (cur_lane),
        .player_lost    (player_lost)
    );

    // Reference model: frame history and run lengths, updated once per frame.
    int m_hist[$];
    int m_acc[$];
    int m_target = 1, m_cur = 1, m_jrun = 0, m_since = 1000, m_lrun = 0;
    bit m_pending = 0, m_lost = 0, m_dv = 0;
    int cyc = 0, last_acc = -1000;
    bit tick, det, arm, same;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_hist.delete();
            m_target = 1; m_cur = 1; m_jrun = 0; m_since = 1000; m_lrun = 0;
            m_pending = 0; m_lost = 0; m_dv = 0; last_acc = -1000;
        end else begin
            tick = dv && !m_dv;
            m_dv = dv;
            arm = 0;
            if (tick) begin
                det = (quads != 0) && (lane != 2'd3);
                if (det) begin
                    m_lrun = 0; m_lost = 0;
                    m_hist.push_back(int'(lane));
                    if (m_hist.size() > 16) void'(m_hist.pop_front());
                    if (m_hist.size() >= SF) begin
                        same = 1;
                        for (int k = 0; k < SF; k++)
                            if (m_hist[m_hist.size()-1-k] != int'(lane)) same = 0;
                        if (same) m_target = int'(lane);
                    end
                    if (jump) begin
                        m_jrun++;
                        if (m_jrun == JF) arm = 1;
                    end else m_jrun = 0;
                end else begin
                    m_hist.delete();
                    m_jrun = 0;
                    m_lrun++;
                    if (m_lrun >= LF) m_lost = 1;
                end
                if (arm && m_since >= CF) m_pending = 1;
                if (m_since < 1000) m_since++;
            end
            if (cmd_valid && ready) begin
                m_acc.push_back(int'(cmd_code));
                last_acc = cyc;
                case (cmd_code)
                    2'd1: m_cur--;
                    2'd2: m_cur++;
                    2'd3: begin m_pending = 0; m_since = 0; end
                    default: ;
                endcase
            end
        end
    end

    // Handshake monitor, sampled on the falling edge.
    bit       prev_valid = 0;
    logic [1:0] prev_code = 2'd0;
    int       want_prev = 0, want;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 0;
            want_prev  = 0;
        end else begin
            total++;
            if (cur_lane !== 2'(m_cur)) $display("FAIL cur_lane t=%0t got %0d want %0d", $time, cur_lane, m_cur);
            else passed++;
            total++;
            if (player_lost !== m_lost) $display("FAIL player_lost t=%0t got %0b want %0b", $time, player_lost, m_lost);
            else passed++;
            if (!cmd_valid) begin
                total++;
                if (cmd_code !== 2'd0) $display("FAIL idle_code t=%0t got %0d want 0", $time, cmd_code);
                else passed++;
            end else if (!prev_valid) begin
                total++;
                if (int'(cmd_code) != want_prev || want_prev == 0)
                    $display("FAIL offer_code t=%0t got %0d want %0d", $time, cmd_code, want_prev);
                else passed++;
                total++;
                if (cyc - last_acc < GC + 2)
                    $display("FAIL gap t=%0t got %0d cycles want >= %0d", $time, cyc - last_acc, GC + 2);
                else passed++;
            end else begin
                total++;
                if (cmd_code !== prev_code) $display("FAIL code_hold t=%0t got %0d want %0d", $time, cmd_code, prev_code);
                else passed++;
            end
            if (!en || m_lost)          want = 0;
            else if (m_pending)         want = 3;
            else if (m_target < m_cur)  want = 1;
            else if (m_target > m_cur)  want = 2;
            else                        want = 0;
            prev_valid = cmd_valid;
            prev_code  = cmd_code;
            want_prev  = want;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            ready = 1'($urandom_range(0, 1));
            en    = ($urandom_range(0, 7) != 0);
        end
    endtask

    task automatic frame_t(input logic [1:0] l, input logic j, input logic [8:0] q, input int hold, input int low);
        lane = l; jump = j; quads = q; dv = 1'b1;
        repeat (hold) step();
        dv = 1'b0;
        repeat (low) step();
    endtask

    task automatic frame(input logic [1:0] l, input logic j, input logic [8:0] q);
        frame_t(l, j, q, 2, 2);
    endtask

    function automatic logic [8:0] rq();
        return 9'($urandom_range(1, 511));
    endfunction

    task automatic wait_valid();
        int w = 0;
        while (!cmd_valid && w < 30) begin step(); w++; end
        total++;
        if (cmd_valid !== 1'b1) $display("FAIL wait_valid got %0b want 1 within 30 cycles", cmd_valid);
        else passed++;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; ready = 1'b0; dv = 1'b0;
        repeat (3) step();
        total++; if (cmd_valid !== 1'b0) $display("FAIL reset_valid got %0b want 0", cmd_valid); else passed++;
        total++; if (cmd_code !== 2'd0) $display("FAIL reset_code got %0d want 0", cmd_code); else passed++;
        total++; if (cur_lane !== 2'd1) $display("FAIL reset_lane got %0d want 1", cur_lane); else passed++;
        total++; if (player_lost !== 1'b0) $display("FAIL reset_lost got %0b want 0", player_lost); else passed++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_right_step();
        int n0 = m_acc.size();
        en = 1'b1; ready = 1'b1;
        repeat (3) frame(2'd2, 1'b0, 9'h004);
        repeat (30) step();
        total++; if (m_acc.size() - n0 != 1) $display("FAIL right_count got %0d want 1", m_acc.size() - n0); else passed++;
        total++; if (m_acc.size() > n0 && m_acc[n0] != 2) $display("FAIL right_code got %0d want 2", m_acc[n0]); else passed++;
        total++; if (cur_lane !== 2'd2) $display("FAIL right_lane got %0d want 2", cur_lane); else passed++;
    endtask

    task automatic test_left_two();
        int n0 = m_acc.size();
        repeat (3) frame(2'd0, 1'b0, rq());
        repeat (40) step();
        total++; if (m_acc.size() - n0 != 2) $display("FAIL left_count got %0d want 2", m_acc.size() - n0); else passed++;
        for (int i = n0; i < m_acc.size(); i++) begin
            total++; if (m_acc[i] != 1) $display("FAIL left_code got %0d want 1", m_acc[i]); else passed++;
        end
        total++; if (cur_lane !== 2'd0) $display("FAIL left_lane got %0d want 0", cur_lane); else passed++;
    endtask

    task automatic test_stall();
        logic [1:0] c0;
        ready = 1'b0;
        repeat (3) frame(2'd1, 1'b0, rq());
        wait_valid();
        c0 = cur_lane;
        repeat (10) begin
            step();
            total++;
            if (cmd_valid !== 1'b1 || cmd_code !== 2'd2 || cur_lane !== c0)
                $display("FAIL stall_hold got v=%0b c=%0d l=%0d want v=1 c=2 l=%0d", cmd_valid, cmd_code, cur_lane, c0);
            else passed++;
        end
        ready = 1'b1;
        step();
        total++; if (cur_lane !== 2'd1) $display("FAIL stall_accept_lane got %0d want 1", cur_lane); else passed++;
        repeat (10) step();
    endtask

    task automatic test_jump();
        int n0 = m_acc.size();
        int n1;
        en = 1'b0; ready = 1'b1;
        repeat (3) frame(2'd2, 1'b1, rq());
        en = 1'b1;
        repeat (40) step();
        total++; if (m_acc.size() - n0 != 2) $display("FAIL jump_count got %0d want 2", m_acc.size() - n0); else passed++;
        total++; if (m_acc.size() >= n0 + 2 && (m_acc[n0] != 3 || m_acc[n0+1] != 2))
            $display("FAIL jump_order got %0d,%0d want 3,2", m_acc[n0], m_acc[n0+1]); else passed++;
        n1 = m_acc.size();
        repeat (2) frame(2'd2, 1'b0, rq());
        repeat (2) frame(2'd2, 1'b1, rq());
        repeat (20) step();
        total++; if (m_acc.size() != n1) $display("FAIL cooldown_block got %0d want 0 commands", m_acc.size() - n1); else passed++;
        repeat (20) frame(2'd2, 1'b0, rq());
        repeat (2) frame(2'd2, 1'b1, rq());
        repeat (30) step();
        total++; if (m_acc.size() != n1 + 1 || m_acc[m_acc.size()-1] != 3)
            $display("FAIL cooldown_rearm got %0d commands want 1 JUMP", m_acc.size() - n1); else passed++;
    endtask

    task automatic test_lost();
        int n0 = m_acc.size();
        repeat (14) frame(2'($urandom_range(0, 3)), 1'b0, 9'd0);
        total++; if (player_lost !== 1'b0) $display("FAIL lost_early got %0b want 0", player_lost); else passed++;
        frame(2'($urandom_range(0, 3)), 1'b0, 9'd0);
        total++; if (player_lost !== 1'b1) $display("FAIL lost_15 got %0b want 1", player_lost); else passed++;
        total++; if (m_acc.size() != n0) $display("FAIL lost_cmds got %0d want 0", m_acc.size() - n0); else passed++;
        frame(2'd2, 1'b0, rq());
        total++; if (player_lost !== 1'b0) $display("FAIL lost_clear got %0b want 0", player_lost); else passed++;
        repeat (20) step();
        total++; if (m_acc.size() != n0) $display("FAIL lost_after got %0d want 0", m_acc.size() - n0); else passed++;
    endtask

    task automatic test_alternate();
        int n0 = m_acc.size();
        for (int i = 0; i < 10; i++) frame((i % 2) ? 2'd2 : 2'd0, 1'b0, rq());
        repeat (20) step();
        total++; if (m_acc.size() != n0) $display("FAIL alternate_cmds got %0d want 0", m_acc.size() - n0); else passed++;
        total++; if (cur_lane !== 2'd2) $display("FAIL alternate_lane got %0d want 2", cur_lane); else passed++;
    endtask

    task automatic test_random();
        logic [1:0] fl;
        rnd_mode = 1;
        for (int i = 0; i < 80; i++)
            frame_t(2'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
                    ($urandom_range(0, 5) == 0) ? 9'd0 : rq(),
                    $urandom_range(1, 3), $urandom_range(1, 3));
        rnd_mode = 0;
        en = 1'b1; ready = 1'b1;
        fl = 2'($urandom_range(0, 2));
        repeat (3) frame(fl, 1'b0, rq());
        repeat (80) step();
        total++; if (cur_lane !== fl) $display("FAIL random_settle got %0d want %0d", cur_lane, fl); else passed++;
        total++; if (cmd_valid !== 1'b0) $display("FAIL random_quiet got %0b want 0", cmd_valid); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [1:0] tl;
        tl = (cur_lane == 2'd0) ? 2'd2 : 2'd0;
        ready = 1'b0; en = 1'b1;
        repeat (3) frame(tl, 1'b0, rq());
        wait_valid();
        rst = 1'b1;
        step();
        total++; if (cmd_valid !== 1'b0) $display("FAIL rstmid_valid got %0b want 0", cmd_valid); else passed++;
        total++; if (cur_lane !== 2'd1) $display("FAIL rstmid_lane got %0d want 1", cur_lane); else passed++;
        total++; if (cmd_code !== 2'd0) $display("FAIL rstmid_code got %0d want 0", cmd_code); else passed++;
        rst = 1'b0;
        ready = 1'b1;
        repeat (10) step();
        total++; if (cmd_valid !== 1'b0) $display("FAIL rstmid_quiet got %0b want 0", cmd_valid); else passed++;
    endtask

    initial begin
        test_reset();
        test_right_step();
        test_left_two();
        test_stall();
        test_jump();
        test_lost();
        test_alternate();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
